// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state encoding, bit-period divider, line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

  // Cycles per bit, truncated; callers must keep the result >= 2.
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side handshake bundle of the UART transmitter (valid/ready plus status).
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter 0..DIV-1 with synchronous clear; flags the last and second-to-last cycle.
module uart_baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic tick_c,
  output logic pre_tick_c
);
  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // Reloads to zero on the last cycle of a bit, so it never wraps on its own.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (clear || tick_c) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  assign tick_c     = (cnt == CW'(DIV - 1));
  assign pre_tick_c = (cnt == CW'(DIV - 2));

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and integer-divider bit timing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic      sysclk,
  input  logic      reset,
  uart_tx_if.slave  bus,
  output logic      UART_TX
);
  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [IW-1:0]        idx_q, idx_nxt;
  logic                 line_nxt, done_nxt;
  logic                 accept_c, last_bit_c, tick_c, pre_tick_c;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  assign accept_c   = bus.tx_valid && (state == ST_IDLE);
  assign last_bit_c = (idx_q == IW'(DATA_BITS - 1));

  // Counter is held at zero while idle, so every bit starts a full period.
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .sysclk     (sysclk),
    .reset      (reset),
    .clear      (state == ST_IDLE),
    .tick_c     (tick_c),
    .pre_tick_c (pre_tick_c)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept_c) state_nxt = ST_START;
      ST_START:  if (tick_c)   state_nxt = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (tick_c && last_bit_c) state_nxt = ST_PARITY;
      ST_PARITY: if (tick_c)   state_nxt = ST_STOP;
`else
      ST_DATA:   if (tick_c && last_bit_c) state_nxt = ST_STOP;
`endif
      ST_STOP:   if (tick_c)   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Line value is derived from the next state so UART_TX can be a plain flop.
  always_comb begin
    shift_nxt    = shift_q;
    idx_nxt      = idx_q;
    line_nxt     = LINE_IDLE;
    done_nxt     = 1'b0;
    bus.tx_ready = (state == ST_IDLE);
    bus.tx_busy  = (state != ST_IDLE);

    if (accept_c) begin
      shift_nxt = bus.tx_data;
      idx_nxt   = '0;
    end
    if ((state == ST_DATA) && tick_c) begin
      shift_nxt = shift_q >> 1;
      idx_nxt   = last_bit_c ? '0 : idx_q + IW'(1);
    end

    case (state_nxt)
      ST_START:  line_nxt = 1'b0;
      ST_DATA:   line_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_nxt = par_q;
`endif
      default:   line_nxt = LINE_IDLE;
    endcase

    // Registered one cycle early so the pulse lands on the stop bit's last cycle.
    done_nxt = (state == ST_STOP) && pre_tick_c;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      idx_q       <= '0;
      UART_TX     <= LINE_IDLE;
      bus.tx_done <= 1'b0;
    end else begin
      shift_q     <= shift_nxt;
      idx_q       <= idx_nxt;
      UART_TX     <= line_nxt;
      bus.tx_done <= done_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)         par_q <= 1'b0;
    else if (accept_c) par_q <= ^bus.tx_data;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: accepted bytes are queued by a frame-timing model,
// and a per-cycle monitor checks the serial line, handshake and tx_done against it.
module tb_uart_tx;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * DIV;
`else
  localparam int FRAME = 10 * DIV;
`endif

  typedef struct {
    logic [7:0] data;
    int         acc;
  } frame_t;

  logic sysclk;
  logic reset;
  logic uart_line;

  uart_tx_if #(.DATA_BITS(8)) bus ();

  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .bus     (bus),
    .UART_TX (uart_line)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  frame_t     exp_q[$];
  frame_t     fr;
  int         ready_from = 0;
  logic       prev_ready = 1'b1;
  logic       exp_ready, exp_line, exp_done;
  logic [7:0] rx_byte = '0;
  int         off, slot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  always @(posedge sysclk) begin
    #1;
    cyc++;
    if (reset) begin
      exp_q.delete();
      ready_from = 0;
      prev_ready = 1'b1;
      chk("reset_line",  32'(uart_line),   32'd1);
      chk("reset_ready", 32'(bus.tx_ready), 32'd1);
      chk("reset_busy",  32'(bus.tx_busy),  32'd0);
      chk("reset_done",  32'(bus.tx_done),  32'd0);
    end else begin
      if (bus.tx_valid && prev_ready) begin
        fr.data = bus.tx_data;
        fr.acc  = cyc;
        exp_q.push_back(fr);
        ready_from = cyc + FRAME;
      end
      exp_ready = (cyc >= ready_from);
      exp_line  = 1'b1;
      exp_done  = 1'b0;
      if (exp_q.size() > 0) begin
        fr   = exp_q[0];
        off  = cyc - fr.acc;
        slot = off / DIV;
        if (slot == 0) exp_line = 1'b0;
        else if (slot <= 8) begin
          exp_line = fr.data[slot-1];
          if ((off % DIV) == DIV / 2) rx_byte[slot-1] = uart_line;
        end
`ifdef UART_TX_PARITY_EN
        else if (slot == 9) exp_line = ^fr.data;
`endif
        exp_done = (off == FRAME - 1);
      end
      chk("line",  32'(uart_line),    32'(exp_line));
      chk("ready", 32'(bus.tx_ready), 32'(exp_ready));
      chk("busy",  32'(bus.tx_busy),  32'(!exp_ready));
      chk("done",  32'(bus.tx_done),  32'(exp_done));
      if (exp_done) begin
        chk("rx_byte", 32'(rx_byte), 32'(fr.data));
        void'(exp_q.pop_front());
      end
      prev_ready = exp_ready;
    end
  end

  task automatic wait_ready(input int max);
    int n = 0;
    while (!bus.tx_ready && n < max) begin
      @(negedge sysclk);
      n++;
    end
    if (!bus.tx_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready at cycle %0d: got ready 0 expected 1 within %0d cycles", cyc, max);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge sysclk);
    wait_ready(300);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge sysclk);
    bus.tx_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    repeat (50) @(negedge sysclk);

    send(8'hA5);
    wait_ready(300);

    // Back-to-back with valid held high across the frame boundary.
    @(negedge sysclk);
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    @(negedge sysclk);
    bus.tx_data  = 8'hFF;
    wait_ready(300);
    @(negedge sysclk);
    bus.tx_valid = 1'b0;
    wait_ready(300);

    // Data changes and valid pulses while busy must be ignored.
    send(8'h3C);
    repeat (30) @(negedge sysclk);
    bus.tx_data  = 8'hC3;
    bus.tx_valid = 1'b1;
    @(negedge sysclk);
    bus.tx_valid = 1'b0;
    repeat (20) @(negedge sysclk);
    bus.tx_data  = 8'($urandom);
    bus.tx_valid = 1'b1;
    repeat (3) @(negedge sysclk);
    bus.tx_valid = 1'b0;
    wait_ready(300);

    // Asynchronous reset in the middle of a frame.
    send(8'h55);
    repeat (44) @(negedge sysclk);
    #2 reset = 1'b1;
    #1;
    chk("async_line",  32'(uart_line),    32'd1);
    chk("async_ready", 32'(bus.tx_ready), 32'd1);
    chk("async_busy",  32'(bus.tx_busy),  32'd0);
    chk("async_done",  32'(bus.tx_done),  32'd0);
    @(negedge sysclk);
    reset = 1'b0;
    send(8'h55);
    wait_ready(300);

    send(8'h07);
    send(8'h03);
    wait_ready(300);

    // Random bytes, random gaps, occasional ignored valid pulse mid-frame.
    repeat (15) begin
      repeat ($urandom_range(0, 3)) @(negedge sysclk);
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 80)) @(negedge sysclk);
        bus.tx_data  = 8'($urandom);
        bus.tx_valid = 1'b1;
        @(negedge sysclk);
        bus.tx_valid = 1'b0;
      end
    end
    wait_ready(300);
    repeat (5) @(negedge sysclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
